// File: rtl/sram_page_tracker_pkg.sv
// Shared types and default sizing for the SRAM page tracker.
package sram_page_tracker_pkg;

    localparam int unsigned DEF_NUM_PORTS = 16;
    localparam int unsigned DEF_DEPTH     = 2048;
    localparam int unsigned DEF_ECC_W     = 8;
    localparam int unsigned DEF_JT_W      = 16;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sram_page_tracker_free_fifo.sv
// Free-page list: circular buffer of page addresses with a fall-through head.
module free_page_fifo
    import sram_page_tracker_pkg::*;
#(
    parameter  int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic          pop,
    output logic [AW-1:0] head_c
);

    logic [AW-1:0] mem [DEPTH];
    logic [AW-1:0] head_ptr;
    logic [AW-1:0] tail_ptr;

    // Explicit wrap so non-power-of-two depths stay modulo DEPTH.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_ptr] <= push_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else begin
            if (push) tail_ptr <= ptr_inc(tail_ptr);
            if (pop)  head_ptr <= ptr_inc(head_ptr);
        end
    end

    assign head_c = mem[head_ptr];

endmodule

// File: rtl/sram_page_tracker.sv
// Page allocator: initialises a free list, tracks per-port page counts,
// and hosts the ECC and jump-table side memories.
module sram_page_tracker
    import sram_page_tracker_pkg::*;
#(
    parameter  int unsigned NUM_PORTS = DEF_NUM_PORTS,
    parameter  int unsigned DEPTH     = DEF_DEPTH,
    parameter  int unsigned ECC_W     = DEF_ECC_W,
    parameter  int unsigned JT_W      = DEF_JT_W,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned PW        = $clog2(NUM_PORTS),
    localparam int unsigned CW        = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ecc_wr_en,
    input  logic [AW-1:0]    ecc_wr_addr,
    input  logic [ECC_W-1:0] ecc_din,
    input  logic             ecc_rd_en,
    input  logic [AW-1:0]    ecc_rd_addr,
    output logic [ECC_W-1:0] ecc_dout,
    input  logic             jt_wr_en,
    input  logic [AW-1:0]    jt_wr_addr,
    input  logic [JT_W-1:0]  jt_din,
    input  logic             jt_rd_en,
    input  logic [AW-1:0]    jt_rd_addr,
    output logic [JT_W-1:0]  jt_dout,
    input  logic             alloc_req,
    input  logic [PW-1:0]    alloc_port,
    output logic             alloc_valid,
    output logic [AW-1:0]    alloc_ptr,
    input  logic             free_req,
    input  logic [PW-1:0]    free_port,
    input  logic [AW-1:0]    free_addr,
    input  logic [PW-1:0]    query_port,
    output logic [CW-1:0]    query_amount,
    output logic [CW-1:0]    free_space,
    output logic             list_empty,
    output logic             list_full,
    output logic             init_done,
    output logic             err_alloc_empty,
    output logic             err_free_underflow
);

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   init_cnt;
    logic [CW-1:0]   port_cnt [NUM_PORTS];
    logic            run;
    logic            alloc_ok;
    logic            free_ok;
    logic            push;
    logic            pop;
    logic [AW-1:0]   push_addr;
    logic [CW-1:0]   free_space_d;
    logic [ECC_W-1:0] ecc_mem [DEPTH];
    logic [JT_W-1:0]  jt_mem  [DEPTH];

    assign run          = (state_q == ST_RUN);
    assign list_empty   = (free_space == '0);
    assign list_full    = (free_space == CW'(DEPTH));
    assign alloc_valid  = run && !list_empty;
    assign query_amount = port_cnt[query_port];

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_INIT;
        else        state_q <= state_d;
    end

    // Next state and free-list control; requests are ignored outside RUN.
    always_comb begin
        state_d   = state_q;
        alloc_ok  = 1'b0;
        free_ok   = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_addr = init_cnt;
        case (state_q)
            ST_INIT: begin
                push = 1'b1;
                if (init_cnt == AW'(DEPTH - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                alloc_ok  = alloc_req && alloc_valid;
                free_ok   = free_req && (port_cnt[free_port] != '0);
                pop       = alloc_ok;
                push      = free_ok;
                push_addr = free_addr;
            end
            default: state_d = ST_INIT;
        endcase
        free_space_d = free_space + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_cnt           <= '0;
            free_space         <= '0;
            init_done          <= 1'b0;
            err_alloc_empty    <= 1'b0;
            err_free_underflow <= 1'b0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) port_cnt[i] <= '0;
        end else begin
            free_space <= free_space_d;
            if (!run) init_cnt <= init_cnt + AW'(1);
            if (!run && state_d == ST_RUN) init_done <= 1'b1;
            if (run && alloc_req && !alloc_valid) err_alloc_empty <= 1'b1;
            if (run && free_req && port_cnt[free_port] == '0) err_free_underflow <= 1'b1;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                port_cnt[i] <= port_cnt[i]
                             + CW'(alloc_ok && alloc_port == PW'(i))
                             - CW'(free_ok && free_port == PW'(i));
            end
        end
    end

    free_page_fifo #(
        .DEPTH (DEPTH)
    ) u_free_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (push_addr),
        .pop       (pop),
        .head_c    (alloc_ptr)
    );

    // Side memories: contents survive reset, only the read registers clear.
    always_ff @(posedge clk) begin
        if (ecc_wr_en) ecc_mem[ecc_wr_addr] <= ecc_din;
        if (jt_wr_en)  jt_mem[jt_wr_addr]   <= jt_din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ecc_dout <= '0;
            jt_dout  <= '0;
        end else begin
            if (ecc_rd_en) ecc_dout <= ecc_mem[ecc_rd_addr];
            if (jt_rd_en)  jt_dout  <= jt_mem[jt_rd_addr];
        end
    end

endmodule

// File: tb/tb_sram_page_tracker.sv
// Directed self-checking bench for sram_page_tracker (DEPTH=16, NUM_PORTS=4).
module tb_sram_page_tracker;

    localparam int unsigned NP = 4;
    localparam int unsigned DP = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned PW = 2;
    localparam int unsigned CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ecc_wr_en = 1'b0, ecc_rd_en = 1'b0;
    logic [AW-1:0] ecc_wr_addr = '0, ecc_rd_addr = '0;
    logic [7:0]    ecc_din = '0, ecc_dout;
    logic          jt_wr_en = 1'b0, jt_rd_en = 1'b0;
    logic [AW-1:0] jt_wr_addr = '0, jt_rd_addr = '0;
    logic [15:0]   jt_din = '0, jt_dout;
    logic          alloc_req = 1'b0, alloc_valid;
    logic [PW-1:0] alloc_port = '0;
    logic [AW-1:0] alloc_ptr;
    logic          free_req = 1'b0;
    logic [PW-1:0] free_port = '0, query_port = '0;
    logic [AW-1:0] free_addr = '0;
    logic [CW-1:0] query_amount, free_space;
    logic          list_empty, list_full, init_done, err_alloc_empty, err_free_underflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_page_tracker #(
        .NUM_PORTS (NP),
        .DEPTH     (DP),
        .ECC_W     (8),
        .JT_W      (16)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ecc_wr_en          (ecc_wr_en),
        .ecc_wr_addr        (ecc_wr_addr),
        .ecc_din            (ecc_din),
        .ecc_rd_en          (ecc_rd_en),
        .ecc_rd_addr        (ecc_rd_addr),
        .ecc_dout           (ecc_dout),
        .jt_wr_en           (jt_wr_en),
        .jt_wr_addr         (jt_wr_addr),
        .jt_din             (jt_din),
        .jt_rd_en           (jt_rd_en),
        .jt_rd_addr         (jt_rd_addr),
        .jt_dout            (jt_dout),
        .alloc_req          (alloc_req),
        .alloc_port         (alloc_port),
        .alloc_valid        (alloc_valid),
        .alloc_ptr          (alloc_ptr),
        .free_req           (free_req),
        .free_port          (free_port),
        .free_addr          (free_addr),
        .query_port         (query_port),
        .query_amount       (query_amount),
        .free_space         (free_space),
        .list_empty         (list_empty),
        .list_full          (list_full),
        .init_done          (init_done),
        .err_alloc_empty    (err_alloc_empty),
        .err_free_underflow (err_free_underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [PW-1:0] port, input int exp);
        query_port = port;
        #1;
        chk(tag, 32'(query_amount), 32'(exp));
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_free_space", 32'(free_space), 32'd0);
        chk("rst_alloc_valid", 32'(alloc_valid), 32'd0);
        chk("rst_ecc_dout", 32'(ecc_dout), 32'd0);
        chk("rst_jt_dout", 32'(jt_dout), 32'd0);
        chk("rst_errs", 32'({err_alloc_empty, err_free_underflow}), 32'd0);

        // INIT: requests must be ignored without raising errors
        rst_n = 1'b1;
        alloc_req = 1'b1;
        free_req = 1'b1;
        free_port = 2'd1;
        repeat (15) tick();
        chk("init15_done", 32'(init_done), 32'd0);
        chk("init15_space", 32'(free_space), 32'd15);
        chk("init15_valid", 32'(alloc_valid), 32'd0);
        chk("init_no_errs", 32'({err_alloc_empty, err_free_underflow}), 32'd0);
        alloc_req = 1'b0;
        free_req = 1'b0;
        tick();
        chk("init16_done", 32'(init_done), 32'd1);
        chk("init16_space", 32'(free_space), 32'd16);
        chk("init16_full", 32'(list_full), 32'd1);
        chk("init16_ptr", 32'(alloc_ptr), 32'd0);
        chk("init16_valid", 32'(alloc_valid), 32'd1);

        // ECC write then read; output holds when rd_en is low
        ecc_wr_en = 1'b1; ecc_wr_addr = 4'd7; ecc_din = 8'hA5;
        tick();
        ecc_wr_en = 1'b0; ecc_rd_en = 1'b1; ecc_rd_addr = 4'd7;
        tick();
        chk("ecc_rd", 32'(ecc_dout), 32'h0A5);
        ecc_rd_en = 1'b0; ecc_rd_addr = 4'd0;
        tick();
        chk("ecc_hold", 32'(ecc_dout), 32'h0A5);

        // Jump table: same-cycle write/read returns the old word
        jt_wr_en = 1'b1; jt_wr_addr = 4'd3; jt_din = 16'h1234;
        tick();
        jt_din = 16'hBEEF; jt_rd_en = 1'b1; jt_rd_addr = 4'd3;
        tick();
        chk("jt_rdw_old", 32'(jt_dout), 32'h1234);
        jt_wr_en = 1'b0;
        tick();
        jt_rd_en = 1'b0;
        chk("jt_rd_new", 32'(jt_dout), 32'hBEEF);

        // Drain the list to port 2 in FIFO order
        alloc_port = 2'd2;
        for (int i = 0; i < 16; i++) begin
            alloc_req = 1'b1;
            chk("drain_ptr", 32'(alloc_ptr), 32'(i));
            tick();
        end
        alloc_req = 1'b0;
        chk_cnt("drain_cnt2", 2'd2, 16);
        chk("drain_empty", 32'(list_empty), 32'd1);
        chk("drain_valid", 32'(alloc_valid), 32'd0);
        chk("drain_no_err", 32'(err_alloc_empty), 32'd0);

        // 17th alloc on empty list
        alloc_req = 1'b1;
        tick();
        alloc_req = 1'b0;
        chk("empty_err", 32'(err_alloc_empty), 32'd1);
        chk("empty_space", 32'(free_space), 32'd0);
        chk_cnt("empty_cnt2", 2'd2, 16);

        // Free underflow on port 1
        free_req = 1'b1; free_port = 2'd1; free_addr = 4'd5;
        tick();
        free_req = 1'b0;
        chk("uf_err", 32'(err_free_underflow), 32'd1);
        chk("uf_space", 32'(free_space), 32'd0);
        chk_cnt("uf_cnt1", 2'd1, 0);

        // Free onto empty list with same-cycle alloc: no bypass
        free_req = 1'b1; free_port = 2'd2; free_addr = 4'd4;
        alloc_req = 1'b1; alloc_port = 2'd0;
        tick();
        alloc_req = 1'b0;
        chk("nobyp_space", 32'(free_space), 32'd1);
        chk_cnt("nobyp_cnt0", 2'd0, 0);
        chk_cnt("nobyp_cnt2", 2'd2, 15);
        chk("nobyp_ptr", 32'(alloc_ptr), 32'd4);

        // Build list [6,7] with port 3 holding page 4
        free_addr = 4'd6;
        tick();
        free_addr = 4'd7;
        tick();
        free_req = 1'b0;
        alloc_req = 1'b1; alloc_port = 2'd3;
        tick();
        alloc_req = 1'b0;
        chk("pre_space", 32'(free_space), 32'd2);
        chk_cnt("pre_cnt3", 2'd3, 1);

        // Same-cycle alloc (port 0) and free of 9 (port 3)
        alloc_req = 1'b1; alloc_port = 2'd0;
        free_req = 1'b1; free_port = 2'd3; free_addr = 4'd9;
        tick();
        free_req = 1'b0;
        chk("both_space", 32'(free_space), 32'd2);
        chk_cnt("both_cnt0", 2'd0, 1);
        chk_cnt("both_cnt3", 2'd3, 0);
        chk("order_ptr7", 32'(alloc_ptr), 32'd7);
        tick();
        alloc_req = 1'b0;
        chk("order_ptr9", 32'(alloc_ptr), 32'd9);

        // Same-cycle alloc and free on the same port
        alloc_req = 1'b1; alloc_port = 2'd2;
        free_req = 1'b1; free_port = 2'd2; free_addr = 4'd11;
        tick();
        alloc_req = 1'b0; free_req = 1'b0;
        chk("same_space", 32'(free_space), 32'd1);
        chk_cnt("same_cnt2", 2'd2, 13);
        chk("same_ptr", 32'(alloc_ptr), 32'd11);

        // Reset from RUN clears counters and sticky errors
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rrun_errs", 32'({err_alloc_empty, err_free_underflow}), 32'd0);
        chk("rrun_done", 32'(init_done), 32'd0);
        chk_cnt("rrun_cnt2", 2'd2, 0);

        // Reset at init cycle 8, then full restart
        repeat (8) tick();
        chk("mid_space", 32'(free_space), 32'd8);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_space", 32'(free_space), 32'd0);
        repeat (15) tick();
        chk("re15_done", 32'(init_done), 32'd0);
        tick();
        chk("re16_done", 32'(init_done), 32'd1);
        chk("re16_space", 32'(free_space), 32'd16);
        chk("re16_ptr0", 32'(alloc_ptr), 32'd0);
        alloc_req = 1'b1; alloc_port = 2'd1;
        tick();
        alloc_req = 1'b0;
        chk("re_ptr1", 32'(alloc_ptr), 32'd1);
        chk_cnt("re_cnt1", 2'd1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_page_tracker.md
SRAM_PAGE_TRACKER -- requirements
Module: sram_page_tracker

Interface
REQ-001 Parameters SHALL be: NUM_PORTS, default 16, number of tracked ports; DEPTH, default 2048, pages per SRAM; ECC_W, default 8, ECC word width; JT_W, default 16, jump-table word width.
REQ-002 Derived widths SHALL be AW=$clog2(DEPTH) and PW=$clog2(NUM_PORTS); counters SHALL be AW+1 bits wide.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 ecc_wr_en/ecc_wr_addr/ecc_din  in  1/AW/ECC_W  ECC storage write.
REQ-006 ecc_rd_en/ecc_rd_addr  in  1/AW; ecc_dout  out  ECC_W  ECC storage read.
REQ-007 jt_wr_en/jt_wr_addr/jt_din  in  1/AW/JT_W  jump-table write.
REQ-008 jt_rd_en/jt_rd_addr  in  1/AW; jt_dout  out  JT_W  jump-table read.
REQ-009 alloc_req  in  1, alloc_port  in  PW  take one free page for a port.
REQ-010 alloc_valid  out  1, alloc_ptr  out  AW  head of the free list, first-word-fall-through.
REQ-011 free_req  in  1, free_port  in  PW, free_addr  in  AW  return a page from a port.
REQ-012 query_port  in  PW; query_amount  out  AW+1  page count of query_port, combinational.
REQ-013 free_space  out  AW+1; list_empty, list_full  out  1 each.
REQ-014 init_done  out  1; err_alloc_empty, err_free_underflow  out  1 each, sticky.

Function
REQ-015 ECC and jump-table storage SHALL be simple dual-port block RAMs with registered read data and 1-cycle read latency; read output SHALL hold when rd_en is low; write and read to the same address in one cycle SHALL return the old data.
REQ-016 The FSM SHALL have states INIT and RUN; reset enters INIT.
REQ-017 INIT SHALL push addresses 0..DEPTH-1, one per cycle, into the free list and increment free_space each cycle; after DEPTH cycles it SHALL enter RUN and set init_done=1.
REQ-018 In INIT, alloc_valid SHALL be 0; alloc_req and free_req SHALL be ignored, with no error flags set.
REQ-019 In RUN, alloc_valid SHALL equal !list_empty, and alloc_ptr SHALL show the oldest free address.
REQ-020 An accepted alloc (alloc_req & alloc_valid) SHALL pop the head, decrement free_space, and increment the count of alloc_port, all on the same edge.
REQ-021 alloc_req while alloc_valid=0 in RUN SHALL change no state and SHALL set err_alloc_empty.
REQ-022 An accepted free (free_req in RUN with count[free_port]!=0) SHALL push free_addr at the tail, increment free_space, and decrement count[free_port].
REQ-023 free_req with count[free_port]==0 SHALL change no state and SHALL set err_free_underflow.
REQ-024 Simultaneous accepted alloc and free SHALL leave free_space unchanged; with equal ports the count SHALL be unchanged; with different ports one SHALL be +1 and the other -1.
REQ-025 A free on an empty list SHALL NOT bypass to a same-cycle alloc; that alloc SHALL be rejected per REQ-021.
REQ-026 list_empty SHALL be (free_space==0); list_full SHALL be (free_space==DEPTH); the free-list pointers SHALL wrap modulo DEPTH.
REQ-027 Error flags SHALL be cleared only by reset.

Reset
REQ-028 On rst_n=0: state=INIT, free_space=0, all port counts=0, list pointers=0, init_done=0, error flags=0, ecc_dout=0, jt_dout=0; RAM contents SHALL be retained.
REQ-029 Reset asserted mid-INIT or mid-RUN SHALL restart INIT from address 0 on the first cycle after release.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the default parameter constants.
REQ-031 The free list SHALL be one sub-module, free_page_fifo (DEPTH x AW RAM, head/tail pointers, FWFT head output); the FSM, counters and error logic SHALL sit in the top level.

Verification
REQ-032 Bench parameters: DEPTH=16, NUM_PORTS=4. Reset, then wait: init_done rises after exactly 16 cycles with free_space=16, list_full=1, alloc_ptr=0.
REQ-033 Bench SHALL cover: 16 allocs to port 2 return addresses 0..15 in order, then query_amount(2)=16, list_empty=1; a 17th alloc sets err_alloc_empty with state unchanged.
REQ-034 Bench SHALL cover: free_req of addr 5 on port 1 with count 0 sets err_free_underflow with free_space unchanged.
REQ-035 Bench SHALL cover: same-cycle alloc on port 0 and free of addr 9 on port 3 give free_space unchanged, count0 +1, count3 -1, and addr 9 is allocated after the older entries.
REQ-036 Bench SHALL cover: write ECC addr 7 = 0xA5 and read it the next cycle, so ecc_dout=0xA5 one cycle later; a same-cycle write/read of jt addr 3 returns the old value.
REQ-037 Bench SHALL cover: reset asserted at init cycle 8 gives init restarting at 0 and init_done 16 cycles after release.
